// File: rtl/dmem_pkg.sv
// Shared types and MMIO address map for the data memory block.
// The DMEM_STATS_EN macro enables the access counters at RD_CNT_ADDR and WR_CNT_ADDR.
package dmem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        DEC_RAM      = 3'd0,
        DEC_LED      = 3'd1,
        DEC_SW       = 3'd2,
        DEC_STAT     = 3'd3,
        DEC_UNMAPPED = 3'd4
    } dec_t;

    localparam logic [15:0] LED_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] SW_ADDR_DEF  = 16'hBF01;
    localparam logic [15:0] RD_CNT_ADDR  = 16'hBF02;
    localparam logic [15:0] WR_CNT_ADDR  = 16'hBF03;

endpackage

// File: rtl/dmem_mmio_regs.sv
// LED register, switch read path and the access counters.
// The counters exist only when DMEM_STATS_EN is defined.
module dmem_mmio_regs
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                acc,
    input  logic                we,
    input  dec_t                sel,
`ifdef DMEM_STATS_EN
    input  logic                stat_idx,
`endif
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   sw,
    output logic [DATA_W-1:0]   led,
    output logic [DATA_W-1:0]   rd_val
);

    logic [DATA_W-1:0] led_r;

    // LED register with per-byte write enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= '0;
        end else if (acc && we && (sel == DEC_LED)) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    led_r[i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign led = led_r;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_r;
    logic [15:0] wr_cnt_r;

    // Saturating RAM access counters; any write to a counter address clears both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_r <= 16'd0;
            wr_cnt_r <= 16'd0;
        end else if (acc && we && (sel == DEC_STAT)) begin
            rd_cnt_r <= 16'd0;
            wr_cnt_r <= 16'd0;
        end else begin
            if (acc && !we && (sel == DEC_RAM) && (rd_cnt_r != 16'hFFFF)) begin
                rd_cnt_r <= rd_cnt_r + 16'd1;
            end
            if (acc && we && (sel == DEC_RAM) && (wr_cnt_r != 16'hFFFF)) begin
                wr_cnt_r <= wr_cnt_r + 16'd1;
            end
        end
    end
`endif

    // Read mux for the register-mapped addresses; sw is taken live so the
    // caller's read register captures it on the acceptance edge
    always_comb begin
        rd_val = '0;
        case (sel)
            DEC_LED: rd_val = led_r;
            DEC_SW:  rd_val = sw;
`ifdef DMEM_STATS_EN
            DEC_STAT: rd_val = stat_idx ? DATA_W'(wr_cnt_r) : DATA_W'(rd_cnt_r);
`endif
            default: rd_val = '0;
        endcase
    end

endmodule

// File: rtl/data_memory_mmio.sv
// Data memory with byte-enable writes, registered reads, zero-clear after reset
// and LED/switch MMIO. Define DMEM_STATS_EN to add the access counters.
module data_memory_mmio
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(LED_ADDR_DEF),
    parameter logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(SW_ADDR_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   sw,
    output logic                ready,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic [DATA_W-1:0]   led
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CLR_LAST = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);

    state_t            state_r;
    logic [CNT_W-1:0]  clr_cnt_r;
    logic              ready_r;
    logic              rvalid_r;
    logic              err_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              acc_s;
    dec_t              sel_s;
    logic [CNT_W-1:0]  ram_idx_s;
    logic [DATA_W-1:0] reg_rdata_s;
    logic [DATA_W-1:0] rd_mux_s;
`ifdef DMEM_STATS_EN
    logic              stat_idx_s;
    assign stat_idx_s = (addr == ADDR_W'(WR_CNT_ADDR));
`endif

    assign acc_s     = req && ready_r;
    assign ram_idx_s = addr[CNT_W-1:0];

    // Address decode
    always_comb begin
        sel_s = DEC_UNMAPPED;
        if ({1'b0, addr} < DEPTH_A) begin
            sel_s = DEC_RAM;
        end else if (addr == LED_ADDR) begin
            sel_s = DEC_LED;
        end else if (addr == SW_ADDR) begin
            sel_s = DEC_SW;
`ifdef DMEM_STATS_EN
        end else if ((addr == ADDR_W'(RD_CNT_ADDR)) || (addr == ADDR_W'(WR_CNT_ADDR))) begin
            sel_s = DEC_STAT;
`endif
        end else begin
            sel_s = DEC_UNMAPPED;
        end
    end

    // Clear FSM: one RAM word zeroed per cycle, then ready until the next reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + CNT_W'(1);
                    if (clr_cnt_r == CLR_LAST) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_cnt_r <= '0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // RAM array: no reset on the storage itself, the clear FSM zeroes it
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r] <= '0;
        end else if (acc_s && we && (sel_s == DEC_RAM)) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (be[i]) begin
                    mem_r[ram_idx_s][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    dmem_mmio_regs #(
        .DATA_W (DATA_W)
    ) u_regs (
        .clk      (clk),
        .rst_n    (rst_n),
        .acc      (acc_s),
        .we       (we),
        .sel      (sel_s),
`ifdef DMEM_STATS_EN
        .stat_idx (stat_idx_s),
`endif
        .be       (be),
        .wdata    (wdata),
        .sw       (sw),
        .led      (led),
        .rd_val   (reg_rdata_s)
    );

    // Read data source selection
    always_comb begin
        rd_mux_s = '0;
        case (sel_s)
            DEC_RAM:      rd_mux_s = mem_r[ram_idx_s];
            DEC_UNMAPPED: rd_mux_s = '0;
            default:      rd_mux_s = reg_rdata_s;
        endcase
    end

    // Registered read response and error strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
            rdata_r  <= '0;
        end else begin
            rvalid_r <= acc_s && !we;
            err_r    <= acc_s && (sel_s == DEC_UNMAPPED);
            if (acc_s && !we) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    assign ready  = ready_r;
    assign rvalid = rvalid_r;
    assign err    = err_r;
    assign rdata  = rdata_r;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Self-checking bench for data_memory_mmio: clear timing, RAM/MMIO accesses,
// unmapped decode, mid-clear reset; counter checks follow DMEM_STATS_EN.
module tb_data_memory_mmio;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic        ready;
    logic        rvalid;
    logic [15:0] rdata;
    logic        err;
    logic [15:0] led;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        req;
        logic        we;
        logic [1:0]  be;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sw;
        logic        rv;
        logic        err;
        logic [15:0] rd;
        logic [15:0] led;
    } vec_t;

    typedef struct {
        logic        rv;
        logic        err;
        logic [15:0] rd;
        logic [15:0] led;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[18];

    data_memory_mmio dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .sw     (sw),
        .ready  (ready),
        .rvalid (rvalid),
        .rdata  (rdata),
        .err    (err),
        .led    (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected response, compare after the edge
    task automatic access(input logic r, input logic w, input logic [1:0] b,
                          input logic [15:0] a, input logic [15:0] d, input logic [15:0] s,
                          input logic e_rv, input logic e_err, input logic [15:0] e_rd,
                          input logic [15:0] e_led, input string name);
        exp_t e;
        req = r; we = w; be = b; addr = a; wdata = d; sw = s;
        e.rv = e_rv; e.err = e_err; e.rd = e_rd; e.led = e_led;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({name, ".rvalid"}, {31'd0, rvalid}, {31'd0, e.rv});
        chk({name, ".err"},    {31'd0, err},    {31'd0, e.err});
        chk({name, ".rdata"},  {16'd0, rdata},  {16'd0, e.rd});
        chk({name, ".led"},    {16'd0, led},    {16'd0, e.led});
        req = 1'b0;
    endtask

    // Count samples with ready=0 after reset release; bounded, flags stray strobes
    task automatic wait_ready(input string name);
        int n = 0;
        int strobes = 0;
        while (!ready && n < 1000) begin
            if (rvalid || err) strobes++;
            n++;
            @(posedge clk);
            #1;
        end
        chk({name, ".clear_cycles"}, n, 32'd256);
        chk({name, ".no_strobes"}, strobes, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset.ready",  {31'd0, ready},  32'd0);
        chk("reset.rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset.err",    {31'd0, err},    32'd0);
        chk("reset.rdata",  {16'd0, rdata},  32'd0);
        chk("reset.led",    {16'd0, led},    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 2'b00;
        addr = 16'h0000; wdata = 16'h0000; sw = 16'h0000;

        // Initial clear with req held high
        req = 1'b1; addr = 16'h007F;
        do_reset();
        wait_ready("clear1");
        access(1'b1, 1'b1, 2'b11, 16'h007F, 16'hDEAD, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, "w7f");
        access(1'b1, 1'b0, 2'b00, 16'h007F, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hDEAD, 16'h0000, "r7f_pre");

        // Reset again: the clear must wipe the word
        req = 1'b1;
        do_reset();
        wait_ready("clear2");
        access(1'b1, 1'b0, 2'b00, 16'h007F, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, "r7f_post");

        //          req   we    be     addr      wdata     sw        rv    err   rdata     led
        vecs[0]  = '{1'b1, 1'b1, 2'b11, 16'h0005, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 16'h0005, 16'h3C00, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h3CA5, 16'h0000};
        vecs[3]  = '{1'b1, 1'b1, 2'b11, 16'hBF00, 16'h00FF, 16'h0000, 1'b0, 1'b0, 16'h3CA5, 16'h00FF};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 16'hBF00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h00FF, 16'h00FF};
        vecs[5]  = '{1'b1, 1'b1, 2'b11, 16'hBF01, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h00FF, 16'h00FF};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 16'hBF01, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF, 16'h00FF};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h00FF};
        vecs[8]  = '{1'b1, 1'b1, 2'b11, 16'h0100, 16'h5555, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00FF};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h00FF};
        vecs[10] = '{1'b1, 1'b1, 2'b10, 16'hBF00, 16'hAB00, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hABFF};
        vecs[11] = '{1'b1, 1'b1, 2'b00, 16'h0005, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hABFF};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h3CA5, 16'hABFF};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hABFF};
        vecs[14] = '{1'b1, 1'b1, 2'b11, 16'h00FF, 16'h1357, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'hABFF};
        vecs[15] = '{1'b1, 1'b0, 2'b00, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1357, 16'hABFF};
        vecs[16] = '{1'b1, 1'b0, 2'b00, 16'hBF00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hABFF, 16'hABFF};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hABFF, 16'hABFF};

        for (int i = 0; i < 18; i++) begin
            access(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].sw,
                   vecs[i].rv, vecs[i].err, vecs[i].rd, vecs[i].led, $sformatf("vec%0d", i));
        end

`ifdef DMEM_STATS_EN
        access(1'b1, 1'b1, 2'b11, 16'hBF02, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hABFF, 16'hABFF, "st_clr0");
        access(1'b1, 1'b0, 2'b00, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hABFF, "st_r1");
        access(1'b1, 1'b0, 2'b00, 16'h0002, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hABFF, "st_r2");
        access(1'b1, 1'b0, 2'b00, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h3CA5, 16'hABFF, "st_r3");
        access(1'b1, 1'b1, 2'b11, 16'h0010, 16'h1111, 16'h0000, 1'b0, 1'b0, 16'h3CA5, 16'hABFF, "st_w1");
        access(1'b1, 1'b1, 2'b00, 16'h0011, 16'h2222, 16'h0000, 1'b0, 1'b0, 16'h3CA5, 16'hABFF, "st_w2");
        access(1'b1, 1'b0, 2'b00, 16'hBF02, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'hABFF, "st_rdcnt");
        access(1'b1, 1'b0, 2'b00, 16'hBF03, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0002, 16'hABFF, "st_wrcnt");
        access(1'b1, 1'b1, 2'b11, 16'hBF03, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'hABFF, "st_clr1");
        access(1'b1, 1'b0, 2'b00, 16'hBF02, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hABFF, "st_rdcnt0");
        access(1'b1, 1'b0, 2'b00, 16'hBF03, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'hABFF, "st_wrcnt0");
`else
        access(1'b1, 1'b0, 2'b00, 16'hBF02, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hABFF, "nost_r2");
        access(1'b1, 1'b1, 2'b11, 16'hBF03, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hABFF, "nost_w3");
        access(1'b1, 1'b0, 2'b00, 16'hBF03, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'hABFF, "nost_r3");
`endif

        // Asynchronous reset mid-operation clears led, then a reset 100 cycles into CLEAR
        req = 1'b1; addr = 16'h0005;
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        chk("midclear.ready_before", {31'd0, ready}, 32'd0);
        do_reset();
        wait_ready("clear3");
        access(1'b1, 1'b0, 2'b00, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, "r5_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
- Next-generation data memory for the MIPS-style core: synchronous, parametrised width/depth, byte-enable writes, registered reads with a valid strobe.
- Memory-mapped I/O decode: LED output register and switch input register.
- Hardware zero-clear of the RAM after every reset.
- Sits between the core's MEM stage and board I/O.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width.
- DEPTH, 256, number of RAM words; valid RAM addresses are 0..DEPTH-1.
- LED_ADDR, 16'hBF00, MMIO address of the LED register (read/write).
- SW_ADDR, 16'hBF01, MMIO address of the switch register (read-only).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  access request, sampled when ready=1.
- we  in  1  1=write, 0=read; qualified by req.
- be  in  DATA_W/8  byte enables for writes; ignored for reads.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- sw  in  DATA_W  board switch inputs.
- ready  out  1  block accepts requests (0 while clearing).
- rvalid  out  1  one-cycle pulse: rdata valid for the accepted read.
- rdata  out  DATA_W  read data, held until the next read completes.
- err  out  1  one-cycle pulse: accepted access hit an unmapped address.
- led  out  DATA_W  LED register contents.

Behaviour:
- Reset asynchronous, active-low. During and immediately after reset: ready=0, rvalid=0, err=0, rdata=0, led=0, FSM=CLEAR, clear counter=0.
- FSM CLEAR:
  - Each cycle writes 0 to RAM[counter], then increments the counter.
  - On counter==DEPTH-1 the FSM moves to IDLE the next cycle; clearing takes exactly DEPTH cycles.
  - req is ignored; no rvalid/err generated.
- FSM IDLE: ready=1; the FSM stays in IDLE until reset.
- Reset asserted mid-clear or mid-operation: immediate return to reset values; the clear restarts from 0.
- Accepted access = req & ready at a rising edge. One access per cycle, no back-pressure in IDLE.
- Write to RAM (addr<DEPTH): byte lane i is updated only if be[i]=1. be=0 is a legal no-op, no err.
- Write to LED_ADDR: same byte-lane rule applied to led; takes effect on the edge of acceptance.
- Write to SW_ADDR: silently dropped, no err.
- Read latency = 1 cycle: rvalid=1 and rdata updated in the cycle after acceptance.
  - RAM read returns the stored word.
  - LED_ADDR read returns led.
  - SW_ADDR read returns sw sampled at the acceptance edge.
- Read-after-write to the same address on consecutive cycles returns the new data. Write-first behaviour needs no bypass because the read is registered.
- Unmapped address (addr>=DEPTH and not an MMIO address): err=1 the next cycle.
  - Writes are dropped.
  - Reads still pulse rvalid, with rdata=0.
- rdata and led hold their values when there is no relevant access. rvalid/err are never asserted together except on an unmapped read.

Optional Feature:
- Macro: DMEM_STATS_EN.
- With it defined:
  - Two 16-bit saturating counters, RD_CNT and WR_CNT, count accepted RAM-range reads/writes (writes counted regardless of be).
  - They are readable at 16'hBF02 and 16'hBF03, zero-extended or truncated to DATA_W.
  - Any write to either address clears both counters, with no err.
  - The counters reset to 0 and are not incremented during CLEAR.
- Without it: 16'hBF02/16'hBF03 decode as unmapped (err, rdata=0) and no counter logic exists.

Decomposition:
- Package dmem_pkg holds:
  - the FSM state typedef (CLEAR, IDLE);
  - MMIO address constants (LED, SW, RD_CNT, WR_CNT);
  - an address-decode enum (RAM, LED, SW, STAT, UNMAPPED).
- One natural sub-module, dmem_mmio_regs: LED register, switch sampling and the optional stats counters. The top level keeps the RAM array, clear FSM and decode.

Test Plan:
- Release rst_n, req held at 1 -> ready=0 for exactly 256 cycles, no rvalid; then ready=1. A read of addr 8'h7F returns 0 even though it was written with 16'hDEAD before reset.
- Write 16'hA5A5 to addr 5 with be=2'b11, then write 16'h3C00 with be=2'b10, then read addr 5 -> rvalid one cycle after acceptance, rdata=16'h3C00 | 16'h00A5 = 16'h3CA5.
- Write 16'h00FF to 16'hBF00 -> led=16'h00FF on the next edge. Read 16'hBF00 -> rdata=16'h00FF. Write 16'h1234 to 16'hBF01 -> no change, no err.
- sw=16'hBEEF and read 16'hBF01 -> rdata=16'hBEEF. Read addr 16'h0100 -> rvalid=1, err=1, rdata=0. Write addr 16'h0100 -> err=1, RAM unchanged.
- Assert rst_n low 100 cycles into CLEAR with led=16'h00FF -> led=0, ready=0; a full 256-cycle clear restarts.
- With DMEM_STATS_EN: 3 RAM reads + 2 RAM writes, then read 16'hBF02/16'hBF03 -> 3 and 2. Write 16'hBF02 -> both read back 0.
